// File: rtl/divider_pkg.sv
// Shared definitions for the pipelined restoring divider: datapath sizing and
// the stage-to-stage bundle used by the chain-level wrapper.
package divider_pkg;

  localparam int unsigned MAX_DATAPATH = 64;
  localparam int unsigned MAX_DIVISOR  = 32;

  function automatic int unsigned datapath_len(input int unsigned dividendlen,
                                               input int unsigned divisorlen);
    return dividendlen + divisorlen - 1;
  endfunction

  // Sized for the widest supported chain; narrower chains use the low bits.
  typedef struct packed {
    logic                    valid;
    logic [MAX_DATAPATH-1:0] rem;
    logic [MAX_DIVISOR-1:0]  div;
    logic [MAX_DATAPATH-1:0] quo;
  } stage_t;

endpackage

// File: rtl/divider_slice_core.sv
// Combinational compare-and-subtract for one restoring-division step:
// align the divisor to bit SHIFT, subtract it if it fits, flag quotient bit SHIFT.
module divider_slice_core
  import divider_pkg::*;
#(
  parameter int unsigned SHIFT       = 2,
  parameter int unsigned DIVIDENDLEN = 3,
  parameter int unsigned DIVISORLEN  = 2,
  localparam int unsigned DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
  input  logic [DATAPATHLEN-1:0] din_i,
  input  logic [DIVISORLEN-1:0]  divisor_i,
  output logic [DATAPATHLEN-1:0] quo_o,
  output logic [DATAPATHLEN-1:0] rem_o,
  output logic [DIVISORLEN-1:0]  div_o
);

  logic [DATAPATHLEN-1:0] d_al;
  logic                   fit;

  // SHIFT+DIVISORLEN never exceeds DATAPATHLEN, so the aligned divisor is exact.
  always_comb begin
    d_al        = DATAPATHLEN'(divisor_i) << SHIFT;
    fit         = (din_i >= d_al);
    rem_o       = fit ? (din_i - d_al) : din_i;
    quo_o       = '0;
    quo_o[SHIFT] = fit;
    div_o       = divisor_i;
  end

endmodule

// File: rtl/divider_slice.sv
// One registered pipeline stage of the restoring divider: the combinational
// step followed by a 1-cycle output register with asynchronous clear.
module divider_slice
  import divider_pkg::*;
#(
  parameter int unsigned SHIFT       = 2,
  parameter int unsigned DIVIDENDLEN = 3,
  parameter int unsigned DIVISORLEN  = 2,
  localparam int unsigned DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [DATAPATHLEN-1:0] din,
  input  logic [DIVISORLEN-1:0]  divisor,
  output logic                   valid_out,
  output logic [DATAPATHLEN-1:0] quotient,
  output logic [DATAPATHLEN-1:0] dout,
  output logic [DIVISORLEN-1:0]  divout
);

  logic [DATAPATHLEN-1:0] quo_d, rem_d;
  logic [DIVISORLEN-1:0]  div_d;
  logic                   valid_q;
  logic [DATAPATHLEN-1:0] quo_q, rem_q;
  logic [DIVISORLEN-1:0]  div_q;

  divider_slice_core #(
    .SHIFT       (SHIFT),
    .DIVIDENDLEN (DIVIDENDLEN),
    .DIVISORLEN  (DIVISORLEN)
  ) u_core (
    .din_i     (din),
    .divisor_i (divisor),
    .quo_o     (quo_d),
    .rem_o     (rem_d),
    .div_o     (div_d)
  );

  // Data loads every cycle; consumers qualify it with valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else begin
      valid_q <= valid_in;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end

  assign valid_out = valid_q;
  assign quotient  = quo_q;
  assign dout      = rem_q;
  assign divout    = div_q;

endmodule

// File: tb/tb_divider_slice.sv
// Self-checking bench for divider_slice at default parameters (SHIFT=2, 4-bit datapath).
module tb_divider_slice;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_in = 1'b0;
  logic [3:0] din = '0;
  logic [1:0] divisor = '0;
  logic       valid_out;
  logic [3:0] quotient, dout;
  logic [1:0] divout;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  int e_valid, e_dout, e_quo, e_div;

  divider_slice #(.SHIFT(2), .DIVIDENDLEN(3), .DIVISORLEN(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .din       (din),
    .divisor   (divisor),
    .valid_out (valid_out),
    .quotient  (quotient),
    .dout      (dout),
    .divout    (divout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: one restoring step at bit 2 means "take away 4*divisor if it fits".
  task automatic model(input int d, input int dv, output int r, output int q);
    int w;
    w = dv * 4;
    if (d >= w) begin r = d - w; q = 4; end
    else begin r = d; q = 0; end
  endtask

  // Every negedge: outputs must equal the model of the inputs seen at the last posedge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin e_valid = 0; e_dout = 0; e_quo = 0; e_div = 0; end
      chk("cyc_valid", int'(valid_out), e_valid);
      chk("cyc_dout", int'(dout), e_dout);
      chk("cyc_quotient", int'(quotient), e_quo);
      chk("cyc_divout", int'(divout), e_div);
      if (rst_n) begin
        e_valid = int'(valid_in);
        model(int'(din), int'(divisor), e_dout, e_quo);
        e_div = int'(divisor);
      end else begin
        e_valid = 0; e_dout = 0; e_quo = 0; e_div = 0;
      end
    end
  end

  task automatic drive(input bit v, input int d, input int dv);
    @(posedge clk); #2;
    valid_in = v;
    din      = 4'(d);
    divisor  = 2'(dv);
  endtask

  task automatic expect_next(input string name, input int v, input int d, input int q, input int dv);
    @(posedge clk); #1;
    chk({name, "_valid"}, int'(valid_out), v);
    chk({name, "_dout"}, int'(dout), d);
    chk({name, "_quotient"}, int'(quotient), q);
    chk({name, "_divout"}, int'(divout), dv);
  endtask

  initial begin
    int r, q;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_divout", int'(divout), 0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Model pins: hand-computed results for bit 2 of a 4-bit datapath.
    model(12, 2, r, q); chk("model_12_2_r", r, 4); chk("model_12_2_q", q, 4);
    model(5, 2, r, q);  chk("model_5_2_r", r, 5);  chk("model_5_2_q", q, 0);
    model(15, 3, r, q); chk("model_15_3_r", r, 3); chk("model_15_3_q", q, 4);

    drive(1, 12, 2); expect_next("t1", 1, 4, 4, 2);
    drive(1, 5, 2);  expect_next("t2", 1, 5, 0, 2);
    drive(1, 8, 2);  expect_next("t3a", 1, 0, 4, 2);
    drive(1, 15, 3); expect_next("t3b", 1, 3, 4, 3);
    drive(1, 7, 0);  expect_next("t4", 1, 7, 4, 0);
    drive(0, 9, 1);  expect_next("t4b", 0, 5, 4, 1);

    // Exhaustive sweep of {divisor,din}, random valid.
    for (int i = 0; i < 64; i++) drive(1'($urandom_range(1, 0)), i % 16, i / 16);

    // Random traffic.
    for (int i = 0; i < 150; i++)
      drive(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)));

    // Mid-cycle reset with an item in flight.
    drive(1, 13, 3);
    @(posedge clk); #1;
    chk("pre_rst_dout", int'(dout), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_quotient", int'(quotient), 0);
    chk("mid_rst_divout", int'(divout), 0);
    valid_in = 1'b1; din = 4'd14; divisor = 2'd3;
    @(posedge clk); #1;
    chk("held_rst_valid", int'(valid_out), 0);
    chk("held_rst_dout", int'(dout), 0);
    #1 rst_n = 1'b1;
    expect_next("post_rst", 1, 2, 4, 3);

    repeat (20) drive(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
    @(posedge clk);
    @(negedge clk);
    #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
